// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue between issue and the register file's
// retire lane. Instructions get a tag in program order at dispatch, completions
// arrive out of order, and finished instructions retire strictly in order at
// most one per cycle as a registered pulse.
//
// Optional feature macro: ROB_FLUSH_EN adds i_flush/i_flush_tag, which squash
// every entry younger than a mispredicted branch.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_alloc_*             dispatch request and entry payload
//   o_alloc_ready/_tag    entry available, tag granted (tail index)
//   i_done_*              completion report (tag + result data)
//   o_retire_*            registered retire pulse and fields
//   i_flush, i_flush_tag  squash request (ROB_FLUSH_EN only)
//   o_count, o_empty      occupancy from registered pointers
module reorder_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_alloc_valid,
    output logic                 o_alloc_ready,
    input  logic                 i_alloc_uses_rw,
    input  logic [4:0]           i_alloc_rw_addr,
    input  logic [5:0]           i_alloc_phys,
    output logic [TAG_WIDTH-1:0] o_alloc_tag,
    input  logic                 i_done_valid,
    input  logic [TAG_WIDTH-1:0] i_done_tag,
    input  logic [31:0]          i_done_data,
    output logic                 o_retire_valid,
    output logic                 o_retire_uses_rw,
    output logic [4:0]           o_retire_rw_addr,
    output logic [5:0]           o_retire_phys,
    output logic [31:0]          o_retire_data,
`ifdef ROB_FLUSH_EN
    input  logic                 i_flush,
    input  logic [TAG_WIDTH-1:0] i_flush_tag,
`endif
    output logic [TAG_WIDTH:0]   o_count,
    output logic                 o_empty
);

    localparam int unsigned PtrW = TAG_WIDTH + 1;

    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [PtrW-1:0]      ptr_t;

    localparam ptr_t PtrOne = ptr_t'(1);

    // Entry storage
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        done_q, done_d;
    logic [DEPTH-1:0]        uses_rw_q, uses_rw_d;
    logic [DEPTH-1:0][4:0]   rw_addr_q, rw_addr_d;
    logic [DEPTH-1:0][5:0]   phys_q, phys_d;
    logic [DEPTH-1:0][31:0]  data_q, data_d;

    // Pointers carry a wrap bit above the index
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;

    // Retire lane registers
    logic        ret_valid_q, ret_valid_d;
    logic        ret_uses_rw_q, ret_uses_rw_d;
    logic [4:0]  ret_rw_addr_q, ret_rw_addr_d;
    logic [5:0]  ret_phys_q, ret_phys_d;
    logic [31:0] ret_data_q, ret_data_d;

    tag_t head_idx;
    tag_t tail_idx;
    logic full;
    logic alloc_ready;
    logic alloc_fire;
    logic retire_fire;
    logic done_fire;

    // Squash controls; tied off when the flush feature is not built
    logic             flush_hit;
    ptr_t             flush_ptr;
    logic [DEPTH-1:0] squash;

    assign head_idx = head_q[TAG_WIDTH-1:0];
    assign tail_idx = tail_q[TAG_WIDTH-1:0];

    // Full: indices match, wrap bits differ
    assign full = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);

`ifdef ROB_FLUSH_EN
    assign alloc_ready = !full && !i_flush;
`else
    assign alloc_ready = !full;
`endif

    assign alloc_fire  = i_alloc_valid && alloc_ready;
    assign retire_fire = valid_q[head_idx] && done_q[head_idx];
    assign done_fire   = i_done_valid && valid_q[i_done_tag] && !squash[i_done_tag];

`ifdef ROB_FLUSH_EN
    tag_t flush_off;
    tag_t ent_off;

    // Age of an entry is its distance from head modulo DEPTH; anything older
    // than the flush tag's age survives, anything younger is squashed.
    always_comb begin
        flush_hit = i_flush && valid_q[i_flush_tag];
        flush_off = i_flush_tag - head_idx;
        flush_ptr = head_q + {1'b0, flush_off};
        squash    = '0;
        ent_off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_off   = tag_t'(i) - head_idx;
            squash[i] = flush_hit && (ent_off > flush_off);
        end
    end
`else
    assign flush_hit = 1'b0;
    assign flush_ptr = tail_q;
    assign squash    = '0;
`endif

    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        uses_rw_d = uses_rw_q;
        rw_addr_d = rw_addr_q;
        phys_d    = phys_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;

        ret_valid_d   = 1'b0;
        ret_uses_rw_d = ret_uses_rw_q;
        ret_rw_addr_d = ret_rw_addr_q;
        ret_phys_d    = ret_phys_q;
        ret_data_d    = ret_data_q;

        if (retire_fire) begin
            ret_valid_d       = 1'b1;
            ret_uses_rw_d     = uses_rw_q[head_idx];
            ret_rw_addr_d     = rw_addr_q[head_idx];
            ret_phys_d        = phys_q[head_idx];
            ret_data_d        = data_q[head_idx];
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PtrOne;
        end

        if (done_fire) begin
            done_d[i_done_tag] = 1'b1;
            data_d[i_done_tag] = i_done_data;
        end

        valid_d = valid_d & ~squash;
        done_d  = done_d & ~squash;

        // Flush wins over allocate; alloc_ready already blocks alloc during i_flush
        if (flush_hit) begin
            tail_d = flush_ptr + PtrOne;
        end else if (alloc_fire) begin
            valid_d[tail_idx]   = 1'b1;
            done_d[tail_idx]    = 1'b0;
            uses_rw_d[tail_idx] = i_alloc_uses_rw;
            rw_addr_d[tail_idx] = i_alloc_rw_addr;
            phys_d[tail_idx]    = i_alloc_phys;
            tail_d              = tail_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            done_q        <= '0;
            uses_rw_q     <= '0;
            rw_addr_q     <= '0;
            phys_q        <= '0;
            data_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            ret_valid_q   <= 1'b0;
            ret_uses_rw_q <= 1'b0;
            ret_rw_addr_q <= '0;
            ret_phys_q    <= '0;
            ret_data_q    <= '0;
        end else begin
            valid_q       <= valid_d;
            done_q        <= done_d;
            uses_rw_q     <= uses_rw_d;
            rw_addr_q     <= rw_addr_d;
            phys_q        <= phys_d;
            data_q        <= data_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            ret_valid_q   <= ret_valid_d;
            ret_uses_rw_q <= ret_uses_rw_d;
            ret_rw_addr_q <= ret_rw_addr_d;
            ret_phys_q    <= ret_phys_d;
            ret_data_q    <= ret_data_d;
        end
    end

    assign o_alloc_ready    = alloc_ready;
    assign o_alloc_tag      = tail_idx;
    assign o_retire_valid   = ret_valid_q;
    assign o_retire_uses_rw = ret_uses_rw_q;
    assign o_retire_rw_addr = ret_rw_addr_q;
    assign o_retire_phys    = ret_phys_q;
    assign o_retire_data    = ret_data_q;
    assign o_count          = tail_q - head_q;
    assign o_empty          = (head_q == tail_q);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a scoreboard queue holds the expected
// retire records in program order and a monitor pops and compares every pulse.
module tb_reorder_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TW    = 4;

    logic          clk;
    logic          rst_n;
    logic          i_alloc_valid;
    logic          o_alloc_ready;
    logic          i_alloc_uses_rw;
    logic [4:0]    i_alloc_rw_addr;
    logic [5:0]    i_alloc_phys;
    logic [TW-1:0] o_alloc_tag;
    logic          i_done_valid;
    logic [TW-1:0] i_done_tag;
    logic [31:0]   i_done_data;
    logic          o_retire_valid;
    logic          o_retire_uses_rw;
    logic [4:0]    o_retire_rw_addr;
    logic [5:0]    o_retire_phys;
    logic [31:0]   o_retire_data;
`ifdef ROB_FLUSH_EN
    logic          i_flush;
    logic [TW-1:0] i_flush_tag;
`endif
    logic [TW:0]   o_count;
    logic          o_empty;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_alloc_valid   (i_alloc_valid),
        .o_alloc_ready   (o_alloc_ready),
        .i_alloc_uses_rw (i_alloc_uses_rw),
        .i_alloc_rw_addr (i_alloc_rw_addr),
        .i_alloc_phys    (i_alloc_phys),
        .o_alloc_tag     (o_alloc_tag),
        .i_done_valid    (i_done_valid),
        .i_done_tag      (i_done_tag),
        .i_done_data     (i_done_data),
        .o_retire_valid  (o_retire_valid),
        .o_retire_uses_rw(o_retire_uses_rw),
        .o_retire_rw_addr(o_retire_rw_addr),
        .o_retire_phys   (o_retire_phys),
        .o_retire_data   (o_retire_data),
`ifdef ROB_FLUSH_EN
        .i_flush         (i_flush),
        .i_flush_tag     (i_flush_tag),
`endif
        .o_count         (o_count),
        .o_empty         (o_empty)
    );

    typedef struct {
        logic        uses_rw;
        logic [4:0]  rw_addr;
        logic [5:0]  phys;
        logic [31:0] data;
    } ret_t;

    ret_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every retire pulse must match the oldest expected record
    always @(negedge clk) begin
        if (o_retire_valid) begin
            if (sb.size() == 0) begin
                check_eq("retire_unexpected", 64'd1, 64'd0);
            end else begin
                ret_t e;
                e = sb.pop_front();
                check_eq("retire_uses_rw", {63'd0, o_retire_uses_rw}, {63'd0, e.uses_rw});
                check_eq("retire_rw_addr", {59'd0, o_retire_rw_addr}, {59'd0, e.rw_addr});
                check_eq("retire_phys", {58'd0, o_retire_phys}, {58'd0, e.phys});
                check_eq("retire_data", {32'd0, o_retire_data}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        i_alloc_valid   = 1'b0;
        i_alloc_uses_rw = 1'b0;
        i_alloc_rw_addr = '0;
        i_alloc_phys    = '0;
        i_done_valid    = 1'b0;
        i_done_tag      = '0;
        i_done_data     = '0;
`ifdef ROB_FLUSH_EN
        i_flush         = 1'b0;
        i_flush_tag     = '0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    // Drive an allocation that is known to be accepted and record its retire
    task automatic drive_alloc(input logic uses, input logic [4:0] rw, input logic [5:0] ph,
                               input logic [31:0] d);
        ret_t e;
        i_alloc_valid   = 1'b1;
        i_alloc_uses_rw = uses;
        i_alloc_rw_addr = rw;
        i_alloc_phys    = ph;
        e.uses_rw = uses;
        e.rw_addr = rw;
        e.phys    = ph;
        e.data    = d;
        sb.push_back(e);
    endtask

    task automatic drive_done(input logic [TW-1:0] t, input logic [31:0] d);
        i_done_valid = 1'b1;
        i_done_tag   = t;
        i_done_data  = d;
    endtask

    logic [TW-1:0] order[4];

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        check_eq("rst_count", {59'd0, o_count}, 64'd0);
        check_eq("rst_empty", {63'd0, o_empty}, 64'd1);
        check_eq("rst_ready", {63'd0, o_alloc_ready}, 64'd1);
        check_eq("rst_retire_valid", {63'd0, o_retire_valid}, 64'd0);
        check_eq("rst_retire_data", {32'd0, o_retire_data}, 64'd0);
        rst_n = 1'b1;

        // Test 1: out-of-order completion, in-order retire
        for (int t = 0; t < 4; t++) begin
            check_eq("t1_alloc_tag", {60'd0, o_alloc_tag}, 64'(t));
            drive_alloc(1'b1, 5'(t + 1), 6'(10 + t), 32'hA0 + 32'(t));
            tick();
        end
        idle();
        check_eq("t1_count4", {59'd0, o_count}, 64'd4);
        order[0] = 4'd3; order[1] = 4'd1; order[2] = 4'd2; order[3] = 4'd0;
        for (int k = 0; k < 4; k++) begin
            drive_done(order[k], 32'hA0 + 32'(order[k]));
            tick();
            check_eq("t1_no_early_retire", {63'd0, o_retire_valid}, 64'd0);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t1_pulse", {63'd0, o_retire_valid}, 64'd1);
        end
        tick();
        check_eq("t1_pulse_end", {63'd0, o_retire_valid}, 64'd0);
        check_eq("t1_empty", {63'd0, o_empty}, 64'd1);

        // Test 2: fill to DEPTH, retire one, wrap
        do_reset();
        for (int t = 0; t < DEPTH; t++) begin
            check_eq("t2_ready_fill", {63'd0, o_alloc_ready}, 64'd1);
            drive_alloc(1'b1, 5'(t), 6'(20 + t), 32'h200 + 32'(t));
            tick();
        end
        idle();
        check_eq("t2_full_ready", {63'd0, o_alloc_ready}, 64'd0);
        check_eq("t2_full_count", {59'd0, o_count}, 64'd16);
        i_alloc_valid = 1'b1;
        tick();
        check_eq("t2_refused_count", {59'd0, o_count}, 64'd16);
        drive_done(4'd0, 32'h200);
        tick();
        i_done_valid = 1'b0;
        check_eq("t2_still_full", {63'd0, o_alloc_ready}, 64'd0);
        // Retire edge with alloc still requested: full refuses it
        tick();
        check_eq("t2_retire_pulse", {63'd0, o_retire_valid}, 64'd1);
        check_eq("t2_count15", {59'd0, o_count}, 64'd15);
        check_eq("t2_ready_back", {63'd0, o_alloc_ready}, 64'd1);
        check_eq("t2_wrap_tag", {60'd0, o_alloc_tag}, 64'd0);
        drive_alloc(1'b0, 5'd31, 6'd63, 32'h0);
        tick();
        idle();
        check_eq("t2_refull_count", {59'd0, o_count}, 64'd16);
        check_eq("t2_refull_ready", {63'd0, o_alloc_ready}, 64'd0);

        // Test 3: simultaneous alloc, complete and retire at count 5
        do_reset();
        for (int t = 0; t < 5; t++) begin
            drive_alloc(t[0], 5'(t + 7), 6'(30 + t), 32'h300 + 32'(t));
            tick();
        end
        idle();
        drive_done(4'd0, 32'h300);
        tick();
        idle();
        check_eq("t3_count5", {59'd0, o_count}, 64'd5);
        drive_alloc(1'b1, 5'd12, 6'd35, 32'h305);
        drive_done(4'd2, 32'h302);
        tick();
        idle();
        check_eq("t3_count_stays", {59'd0, o_count}, 64'd5);
        check_eq("t3_retire_same", {63'd0, o_retire_valid}, 64'd1);
        check_eq("t3_next_tag", {60'd0, o_alloc_tag}, 64'd6);
        drive_done(4'd1, 32'h301);
        tick();
        idle();
        check_eq("t3_wait_tag1", {63'd0, o_retire_valid}, 64'd0);
        tick();
        check_eq("t3_retire_tag1", {63'd0, o_retire_valid}, 64'd1);
        tick();
        check_eq("t3_retire_tag2", {63'd0, o_retire_valid}, 64'd1);
        tick();
        check_eq("t3_stall_tag3", {63'd0, o_retire_valid}, 64'd0);
        check_eq("t3_count3", {59'd0, o_count}, 64'd3);

        // Test 4: completion to an unallocated tag is ignored
        do_reset();
        drive_done(4'd7, 32'hDEAD);
        tick();
        idle();
        check_eq("t4_count", {59'd0, o_count}, 64'd0);
        check_eq("t4_empty", {63'd0, o_empty}, 64'd1);
        tick();
        check_eq("t4_no_retire", {63'd0, o_retire_valid}, 64'd0);
        for (int t = 0; t < 8; t++) begin
            drive_alloc(1'b1, 5'(t), 6'(40 + t), 32'h400 + 32'(t));
            tick();
        end
        idle();
        for (int t = 0; t < 7; t++) begin
            drive_done(4'(t), 32'h400 + 32'(t));
            tick();
        end
        idle();
        tick();
        tick();
        tick();
        check_eq("t4_tag7_not_done", {59'd0, o_count}, 64'd1);

`ifdef ROB_FLUSH_EN
        // Test 5: flush tag 2 while completing tag 0 and requesting alloc
        do_reset();
        for (int t = 0; t < 6; t++) begin
            drive_alloc(1'b1, 5'(t), 6'(50 + t), 32'h500 + 32'(t));
            tick();
        end
        idle();
        drive_done(4'd0, 32'h500);
        i_flush       = 1'b1;
        i_flush_tag   = 4'd2;
        i_alloc_valid = 1'b1;
        #1;
        check_eq("t5_ready_flush", {63'd0, o_alloc_ready}, 64'd0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) void'(sb.pop_back());
        check_eq("t5_count_after_flush", {59'd0, o_count}, 64'd3);
        check_eq("t5_next_tag", {60'd0, o_alloc_tag}, 64'd3);
        drive_done(4'd4, 32'hBAD);
        tick();
        idle();
        check_eq("t5_retire_tag0", {63'd0, o_retire_valid}, 64'd1);
        check_eq("t5_count2", {59'd0, o_count}, 64'd2);
        drive_alloc(1'b1, 5'd9, 6'd59, 32'h5F3);
        drive_done(4'd1, 32'h501);
        tick();
        idle();
        drive_done(4'd2, 32'h502);
        tick();
        drive_done(4'd3, 32'h5F3);
        tick();
        idle();
        tick();
        tick();
        check_eq("t5_drained", {63'd0, o_empty}, 64'd1);
`endif

        // Test 6: reset mid-operation with six entries pending
        do_reset();
        for (int t = 0; t < 6; t++) begin
            drive_alloc(1'b1, 5'(t), 6'(60 + t), 32'h600 + 32'(t));
            tick();
        end
        idle();
        for (int t = 5; t >= 0; t--) begin
            drive_done(4'(t), 32'h600 + 32'(t));
            tick();
            if (t == 0) begin
                // Tag 0 became done at this edge; a retire would follow next edge
                rst_n = 1'b0;
                idle();
                #1;
                check_eq("t6_rst_count", {59'd0, o_count}, 64'd0);
                check_eq("t6_rst_empty", {63'd0, o_empty}, 64'd1);
                check_eq("t6_rst_retire", {63'd0, o_retire_valid}, 64'd0);
            end
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t6_no_pulse", {63'd0, o_retire_valid}, 64'd0);
        end
        check_eq("t6_sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
